// File: rtl/fpga_rst_req_ctrl.sv
// Reset-request controller: synchronises and debounces the reset sources, stretches nRST_REQ
// through a hold/release FSM, and keeps a sticky record of which sources caused each reset.
module fpga_rst_req_ctrl #(
    parameter int DB_CYCLES   = 12000,
    parameter int HOLD_CYCLES = 64
) (
    input  logic       CLK12MHZ,
    input  logic       ck_rst,
    input  logic       btn_n,
    input  logic       sysresetreq,
    input  logic       lockup,
    input  logic       lockup_rst_en,
    input  logic       cause_clr,
    output logic       nRST_REQ,
    output logic       rst_active,
    output logic [2:0] rst_cause,
    output logic [7:0] req_count
);
    typedef enum logic [1:0] {IDLE, HOLD, WAIT_REL} state_t;

    localparam logic [15:0] DB_LAST   = 16'(DB_CYCLES - 1);
    localparam logic [7:0]  HOLD_LAST = 8'(HOLD_CYCLES - 1);

    logic        btn_s1, btn_s2, sr_s1, sr_s2, lk_s1, lk_s2;
    logic [15:0] db_cnt;
    logic        btn_db, btn_db_q;
    logic        btn_trig, sr_req, lk_req, any_req, accept;
    logic [2:0]  new_bits;
    state_t      state, state_next;
    logic [7:0]  hold_cnt, hold_next;

    // Input synchronisers; the button chain idles high so reset never looks like a press
    always_ff @(posedge CLK12MHZ or negedge ck_rst) begin
        if (!ck_rst) begin
            btn_s1 <= 1'b1;
            btn_s2 <= 1'b1;
            sr_s1  <= 1'b0;
            sr_s2  <= 1'b0;
            lk_s1  <= 1'b0;
            lk_s2  <= 1'b0;
        end else begin
            btn_s1 <= btn_n;
            btn_s2 <= btn_s1;
            sr_s1  <= sysresetreq;
            sr_s2  <= sr_s1;
            lk_s1  <= lockup;
            lk_s2  <= lk_s1;
        end
    end

    always_ff @(posedge CLK12MHZ or negedge ck_rst) begin
        if (!ck_rst) begin
            db_cnt   <= '0;
            btn_db   <= 1'b1;
            btn_db_q <= 1'b1;
        end else begin
            btn_db_q <= btn_db;
            if (btn_s2 == btn_db) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                btn_db <= btn_s2;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 16'd1;
            end
        end
    end

    // Button triggers only on a debounced press edge, so a held button cannot re-trigger
    assign btn_trig = btn_db_q & ~btn_db;
    assign sr_req   = sr_s2;
    assign lk_req   = lk_s2 & lockup_rst_en;
    assign any_req  = btn_trig | sr_req | lk_req;
    assign new_bits = {lk_req, sr_req, btn_trig};

    always_comb begin
        state_next = state;
        hold_next  = hold_cnt;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_next = HOLD;
                    hold_next  = '0;
                    accept     = 1'b1;
                end
            end
            HOLD: begin
                hold_next = hold_cnt + 8'd1;
                if (hold_cnt == HOLD_LAST) begin
                    state_next = WAIT_REL;
                end
            end
            WAIT_REL: begin
                if (btn_db && !sr_req && !lk_req) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs follow the next state so the request asserts on the accepting edge
    always_ff @(posedge CLK12MHZ or negedge ck_rst) begin
        if (!ck_rst) begin
            state      <= IDLE;
            hold_cnt   <= '0;
            nRST_REQ   <= 1'b1;
            rst_active <= 1'b0;
        end else begin
            state      <= state_next;
            hold_cnt   <= hold_next;
            nRST_REQ   <= (state_next == IDLE);
            rst_active <= (state_next != IDLE);
        end
    end

    // A clear coinciding with an accepted request keeps only the new request
    always_ff @(posedge CLK12MHZ or negedge ck_rst) begin
        if (!ck_rst) begin
            rst_cause <= '0;
            req_count <= '0;
        end else if (accept && cause_clr) begin
            rst_cause <= new_bits;
            req_count <= 8'd1;
        end else if (accept) begin
            rst_cause <= rst_cause | new_bits;
            if (req_count != 8'hFF) begin
                req_count <= req_count + 8'd1;
            end
        end else if (cause_clr) begin
            rst_cause <= '0;
            req_count <= '0;
        end
    end

endmodule

// File: tb/tb_fpga_rst_req_ctrl.sv
// Bench for fpga_rst_req_ctrl: expected request events are queued when stimulus is driven and
// matched against events captured from nRST_REQ by a monitor.
module tb_fpga_rst_req_ctrl;
    localparam int DB   = 8;
    localparam int HOLD = 4;

    logic       CLK12MHZ = 1'b0;
    logic       ck_rst = 1'b0;
    logic       btn_n = 1'b1;
    logic       sysresetreq = 1'b0;
    logic       lockup = 1'b0;
    logic       lockup_rst_en = 1'b0;
    logic       cause_clr = 1'b0;
    logic       nRST_REQ, rst_active;
    logic [2:0] rst_cause;
    logic [7:0] req_count;

    typedef struct {
        int         start;
        int         width;
        logic [2:0] cause;
        logic [7:0] count;
    } ev_t;

    ev_t  exp_q[$];
    ev_t  obs_q[$];
    int   cyc = 0;
    int   low_start = 0;
    logic prev_n = 1'b1;
    int   tests = 0;
    int   fails = 0;

    fpga_rst_req_ctrl #(.DB_CYCLES(DB), .HOLD_CYCLES(HOLD)) dut (
        .CLK12MHZ(CLK12MHZ), .ck_rst(ck_rst), .btn_n(btn_n), .sysresetreq(sysresetreq),
        .lockup(lockup), .lockup_rst_en(lockup_rst_en), .cause_clr(cause_clr),
        .nRST_REQ(nRST_REQ), .rst_active(rst_active), .rst_cause(rst_cause), .req_count(req_count)
    );

    always #5 CLK12MHZ = ~CLK12MHZ;

    // Monitor: cyc numbers the rising edges; each completed low pulse becomes one event
    always @(posedge CLK12MHZ) begin
        ev_t o;
        #1;
        cyc++;
        if (prev_n && !nRST_REQ) low_start = cyc;
        if (!prev_n && nRST_REQ) begin
            o.start = low_start;
            o.width = cyc - low_start;
            o.cause = rst_cause;
            o.count = req_count;
            obs_q.push_back(o);
        end
        prev_n = nRST_REQ;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLK12MHZ);
    endtask

    task automatic push_exp(input int start, input int width, input logic [2:0] cause,
                            input logic [7:0] count);
        ev_t e;
        e.start = start;
        e.width = width;
        e.cause = cause;
        e.count = count;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        tick(2);
        tests++;
        if ({nRST_REQ, rst_active, rst_cause, req_count} !== {1'b1, 1'b0, 3'b000, 8'd0}) begin
            fails++;
            $display("FAIL reset_values: got n=%b act=%b cause=%b cnt=%0d, required n=1 act=0 cause=000 cnt=0",
                     nRST_REQ, rst_active, rst_cause, req_count);
        end
        ck_rst = 1'b1;
        tick(12);
        tests++;
        if (nRST_REQ !== 1'b1 || rst_active !== 1'b0 || obs_q.size() != 0) begin
            fails++;
            $display("FAIL idle_after_reset: got n=%b act=%b events=%0d, required n=1 act=0 events=0",
                     nRST_REQ, rst_active, obs_q.size());
        end
    endtask

    task automatic test_sysresetreq();
        ev_t e, o;
        int  t0;
        t0 = cyc;
        sysresetreq = 1'b1;
        push_exp(t0 + 3, HOLD + 1, 3'b010, 8'd1);
        tick(2);
        sysresetreq = 1'b0;
        tests++;
        if (nRST_REQ !== 1'b1) begin
            fails++;
            $display("FAIL sr_latency_early: got n=%b at cycle 2, required 1", nRST_REQ);
        end
        tick(1);
        tests++;
        if (nRST_REQ !== 1'b0 || rst_active !== 1'b1) begin
            fails++;
            $display("FAIL sr_latency: got n=%b act=%b at cycle 3, required n=0 act=1", nRST_REQ, rst_active);
        end
        tick(10);
        tests++;
        if (obs_q.size() == 0) begin
            fails++;
            $display("FAIL sr_event: got 0 events, required 1");
        end else begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            if ({o.start, o.width, o.cause, o.count} !== {e.start, e.width, e.cause, e.count}) begin
                fails++;
                $display("FAIL sr_event: got start=%0d width=%0d cause=%b cnt=%0d, required start=%0d width=%0d cause=%b cnt=%0d",
                         o.start, o.width, o.cause, o.count, e.start, e.width, e.cause, e.count);
            end
        end
        cause_clr = 1'b1;
        tick(1);
        cause_clr = 1'b0;
        tests++;
        if (rst_cause !== 3'b000 || req_count !== 8'd0) begin
            fails++;
            $display("FAIL cause_clr: got cause=%b cnt=%0d, required cause=000 cnt=0", rst_cause, req_count);
        end
    endtask

    task automatic test_button();
        ev_t e, o;
        int  t0;
        for (int i = 0; i < 10; i++) begin
            btn_n = (i % 2 == 0) ? 1'b0 : 1'b1;
            tick(3);
        end
        t0 = cyc;
        btn_n = 1'b0;
        push_exp(t0 + 2 + DB + 1, 20, 3'b001, 8'd1);
        tick(20);
        btn_n = 1'b1;
        tick(20);
        tests++;
        if (obs_q.size() != 1) begin
            fails++;
            $display("FAIL btn_count: got %0d events, required 1", obs_q.size());
        end
        tests++;
        if (obs_q.size() == 0) begin
            fails++;
            $display("FAIL btn_event: got 0 events, required 1");
        end else begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            if ({o.start, o.width, o.cause, o.count} !== {e.start, e.width, e.cause, e.count}) begin
                fails++;
                $display("FAIL btn_event: got start=%0d width=%0d cause=%b cnt=%0d, required start=%0d width=%0d cause=%b cnt=%0d",
                         o.start, o.width, o.cause, o.count, e.start, e.width, e.cause, e.count);
            end
        end
        obs_q.delete();
        exp_q.delete();
        cause_clr = 1'b1;
        tick(1);
        cause_clr = 1'b0;
    endtask

    task automatic test_lockup();
        ev_t o;
        int  t0, t1;
        lockup = 1'b1;
        tick(12);
        tests++;
        if (obs_q.size() != 0 || nRST_REQ !== 1'b1 || rst_cause !== 3'b000) begin
            fails++;
            $display("FAIL lockup_disabled: got events=%0d n=%b cause=%b, required events=0 n=1 cause=000",
                     obs_q.size(), nRST_REQ, rst_cause);
        end
        t0 = cyc;
        lockup_rst_en = 1'b1;
        tick(15);
        t1 = cyc;
        lockup = 1'b0;
        tick(10);
        tests++;
        if (obs_q.size() != 1) begin
            fails++;
            $display("FAIL lockup_event: got %0d events, required 1", obs_q.size());
        end else begin
            o = obs_q.pop_front();
            if (o.start < t0 + 1 || o.start > t0 + 3 || o.start + o.width != t1 + 3 ||
                o.cause !== 3'b100 || o.count !== 8'd1) begin
                fails++;
                $display("FAIL lockup_event: got start=%0d end=%0d cause=%b cnt=%0d, required start %0d..%0d end=%0d cause=100 cnt=1",
                         o.start, o.start + o.width, o.cause, o.count, t0 + 1, t0 + 3, t1 + 3);
            end
        end
        obs_q.delete();
        cause_clr = 1'b1;
        tick(1);
        cause_clr = 1'b0;
    endtask

    task automatic test_simultaneous();
        ev_t e, o;
        int  t0;
        t0 = cyc;
        sysresetreq = 1'b1;
        lockup = 1'b1;
        push_exp(t0 + 3, HOLD + 1, 3'b110, 8'd1);
        tick(2);
        sysresetreq = 1'b0;
        lockup = 1'b0;
        tick(12);
        tests++;
        if (obs_q.size() != 1) begin
            fails++;
            $display("FAIL simul_event: got %0d events, required 1", obs_q.size());
        end else begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            if ({o.start, o.width, o.cause, o.count} !== {e.start, e.width, e.cause, e.count}) begin
                fails++;
                $display("FAIL simul_event: got start=%0d width=%0d cause=%b cnt=%0d, required start=%0d width=%0d cause=%b cnt=%0d",
                         o.start, o.width, o.cause, o.count, e.start, e.width, e.cause, e.count);
            end
        end
        obs_q.delete();
        exp_q.delete();
        cause_clr = 1'b1;
        tick(1);
        cause_clr = 1'b0;
    endtask

    task automatic test_saturation();
        ev_t e, o;
        int  t0;
        for (int i = 0; i < 256; i++) begin
            t0 = cyc;
            sysresetreq = 1'b1;
            push_exp(t0 + 3, HOLD + 1, 3'b010, (i + 1 > 255) ? 8'd255 : 8'(i + 1));
            tick(2);
            sysresetreq = 1'b0;
            tick(8);
            tests++;
            if (obs_q.size() == 0) begin
                fails++;
                $display("FAIL sat_event_%0d: got 0 events, required 1", i);
            end else begin
                e = exp_q.pop_front();
                o = obs_q.pop_front();
                if ({o.start, o.width, o.cause, o.count} !== {e.start, e.width, e.cause, e.count}) begin
                    fails++;
                    $display("FAIL sat_event_%0d: got start=%0d width=%0d cause=%b cnt=%0d, required start=%0d width=%0d cause=%b cnt=%0d",
                             i, o.start, o.width, o.cause, o.count, e.start, e.width, e.cause, e.count);
                end
            end
        end
        tests++;
        if (req_count !== 8'd255 || rst_cause !== 3'b010) begin
            fails++;
            $display("FAIL saturated: got cnt=%0d cause=%b, required cnt=255 cause=010", req_count, rst_cause);
        end
        // Clear lands on the same cycle the lockup request is accepted
        t0 = cyc;
        lockup = 1'b1;
        push_exp(t0 + 3, HOLD + 1, 3'b100, 8'd1);
        tick(2);
        cause_clr = 1'b1;
        tick(1);
        cause_clr = 1'b0;
        lockup = 1'b0;
        tests++;
        if (rst_cause !== 3'b100 || req_count !== 8'd1 || nRST_REQ !== 1'b0) begin
            fails++;
            $display("FAIL clr_with_trigger: got cause=%b cnt=%0d n=%b, required cause=100 cnt=1 n=0",
                     rst_cause, req_count, nRST_REQ);
        end
        tick(10);
        tests++;
        if (obs_q.size() == 0) begin
            fails++;
            $display("FAIL clr_trig_event: got 0 events, required 1");
        end else begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            if ({o.start, o.width, o.cause, o.count} !== {e.start, e.width, e.cause, e.count}) begin
                fails++;
                $display("FAIL clr_trig_event: got start=%0d width=%0d cause=%b cnt=%0d, required start=%0d width=%0d cause=%b cnt=%0d",
                         o.start, o.width, o.cause, o.count, e.start, e.width, e.cause, e.count);
            end
        end
    endtask

    task automatic test_reset_mid();
        ev_t e, o;
        int  t0;
        sysresetreq = 1'b1;
        tick(4);
        sysresetreq = 1'b0;
        tests++;
        if (nRST_REQ !== 1'b0 || rst_cause === 3'b000) begin
            fails++;
            $display("FAIL mid_pre: got n=%b cause=%b, required n=0 cause nonzero", nRST_REQ, rst_cause);
        end
        ck_rst = 1'b0;
        #1;
        tests++;
        if ({nRST_REQ, rst_active, rst_cause, req_count} !== {1'b1, 1'b0, 3'b000, 8'd0}) begin
            fails++;
            $display("FAIL mid_reset: got n=%b act=%b cause=%b cnt=%0d, required n=1 act=0 cause=000 cnt=0",
                     nRST_REQ, rst_active, rst_cause, req_count);
        end
        tick(2);
        ck_rst = 1'b1;
        obs_q.delete();
        exp_q.delete();
        tick(20);
        tests++;
        if (obs_q.size() != 0 || nRST_REQ !== 1'b1) begin
            fails++;
            $display("FAIL no_replay: got events=%0d n=%b, required events=0 n=1", obs_q.size(), nRST_REQ);
        end
        t0 = cyc;
        sysresetreq = 1'b1;
        push_exp(t0 + 3, HOLD + 1, 3'b010, 8'd1);
        tick(2);
        sysresetreq = 1'b0;
        tick(10);
        tests++;
        if (obs_q.size() == 0) begin
            fails++;
            $display("FAIL post_reset_event: got 0 events, required 1");
        end else begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            if ({o.start, o.width, o.cause, o.count} !== {e.start, e.width, e.cause, e.count}) begin
                fails++;
                $display("FAIL post_reset_event: got start=%0d width=%0d cause=%b cnt=%0d, required start=%0d width=%0d cause=%b cnt=%0d",
                         o.start, o.width, o.cause, o.count, e.start, e.width, e.cause, e.count);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sysresetreq();
        test_button();
        test_lockup();
        test_simultaneous();
        test_saturation();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
